// File: rtl/seq_hand_sched.sv
// Round-robin scheduler that streams one requester's hand into a shared
// monotonic-triple detector and reports the number of flagged triples.
module seq_hand_sched #(
    parameter int NREQ = 4,
    parameter int LENW = 4,
    parameter int DW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] hand_len,
    input  logic [NREQ*DW-1:0]   card_data,
    output logic [NREQ-1:0]      card_pop,
    output logic                 seq_in_valid,
    output logic [DW-1:0]        seq_in_data,
    input  logic                 seq_out_valid,
    input  logic                 seq_out_data,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           done_id,
    output logic [LENW-1:0]      result,
    output logic                 err
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_REPORT} state_t;

    state_t          r_state;
    logic [2:0]      r_rr_ptr;
    logic [2:0]      r_gnt;
    logic [2:0]      r_done_id;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_k;
    logic [LENW-1:0] r_acc;
    logic [LENW-1:0] r_vcnt;
    logic [LENW-1:0] r_result;
    logic [NREQ-1:0] r_card_pop;
    logic            r_seq_in_valid;
    logic            r_done;
    logic            r_err;

    logic [7:0]      w_req8;
    logic [7:0]      w_pick_oh8;
    logic [3:0]      w_sum;
    logic [2:0]      w_pick;
    logic            w_found;
    logic [LENW-1:0] w_len;
    logic [LENW-1:0] w_exp_vcnt;
    logic [2:0]      w_next_rr;

    assign w_req8 = 8'(req);

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_pick_oh8 = '0;
        w_sum      = '0;
        for (int unsigned n = 0; n < NREQ; n++) begin
            w_sum = {1'b0, r_rr_ptr} + 4'(n);
            if (w_sum >= 4'(NREQ))
                w_sum = w_sum - 4'(NREQ);
            if (!w_found && w_req8[w_sum[2:0]]) begin
                w_found    = 1'b1;
                w_pick     = w_sum[2:0];
                w_pick_oh8 = 8'd1 << w_sum[2:0];
            end
        end
    end

    assign w_len      = hand_len[w_pick*LENW +: LENW];
    assign w_exp_vcnt = (r_len >= LENW'(3)) ? r_len - LENW'(2) : '0;
    assign w_next_rr  = (r_gnt == 3'(NREQ-1)) ? '0 : r_gnt + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_gnt          <= '0;
            r_done_id      <= '0;
            r_len          <= '0;
            r_k            <= '0;
            r_acc          <= '0;
            r_vcnt         <= '0;
            r_result       <= '0;
            r_card_pop     <= '0;
            r_seq_in_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // DRAIN still counts: the detector's last output lags the burst by one cycle.
            if ((r_state == S_STREAM || r_state == S_DRAIN) && seq_out_valid) begin
                r_vcnt <= r_vcnt + LENW'(1);
                if (seq_out_data)
                    r_acc <= r_acc + LENW'(1);
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt  <= w_pick;
                        r_len  <= w_len;
                        r_k    <= '0;
                        r_acc  <= '0;
                        r_vcnt <= '0;
                        if (w_len != '0) begin
                            r_state        <= S_STREAM;
                            r_card_pop     <= w_pick_oh8[NREQ-1:0];
                            r_seq_in_valid <= 1'b1;
                        end else begin
                            r_state <= S_REPORT;
                        end
                    end
                end
                S_STREAM: begin
                    r_k <= r_k + LENW'(1);
                    if (r_k == r_len - LENW'(1)) begin
                        r_state        <= S_DRAIN;
                        r_card_pop     <= '0;
                        r_seq_in_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_REPORT;
                end
                S_REPORT: begin
                    r_done    <= 1'b1;
                    r_done_id <= r_gnt;
                    r_result  <= r_acc;
                    r_rr_ptr  <= w_next_rr;
                    if (r_vcnt != w_exp_vcnt)
                        r_err <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign card_pop     = r_card_pop;
    assign seq_in_valid = r_seq_in_valid;
    assign seq_in_data  = (r_state == S_STREAM) ? card_data[r_gnt*DW +: DW] : '0;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign done_id      = r_done_id;
    assign result       = r_result;
    assign err          = r_err;

endmodule
